// File: rtl/serial_frame_deserializer.sv
// -----------------------------------------------------------------------------
// serial_frame_deserializer
//
// Receives framed serial data one bit per clock, LSB first, and presents each
// completed word on a single-entry parallel output buffer with a valid/ready
// handshake.
//
// Frame on SI (arrival order): start(1), BITS data bits LSB first,
// even-parity bit (XOR of the data bits), stop(0). The idle line is 0.
//
// Ports:
//   CLK     in   system clock, rising edge
//   RST     in   asynchronous active-low reset
//   SI      in   serial bit stream, one bit per rising CLK edge
//   READY   in   consumer takes DOUT when READY and VALID are both high
//   DOUT    out  last completed data word (BITS wide)
//   VALID   out  DOUT holds an unconsumed word
//   PERR    out  parity mismatch flag of the word in DOUT (valid with VALID)
//   FERR    out  one-cycle pulse: stop bit was 1, frame discarded
//   OVERRUN out  one-cycle pulse: completed frame dropped, buffer was full
//
// All outputs are registered; there is no combinational path from SI or
// READY to any output.
// -----------------------------------------------------------------------------
module serial_frame_deserializer #(
   parameter int BITS = 4   // data bits per frame, 2..32
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            SI,
   input  logic            READY,
   output logic [BITS-1:0] DOUT,
   output logic            VALID,
   output logic            PERR,
   output logic            FERR,
   output logic            OVERRUN
);

   localparam int CW = $clog2(BITS);
   localparam logic [CW-1:0] LAST_BIT = CW'(BITS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t          state;
   logic [CW-1:0]   bit_cnt;
   logic [BITS-1:0] shreg;
   logic            par_err;

   // Single sequential process: the receive FSM and the output buffer share
   // the same edge so every output is a plain register.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         // NOTE: the shift register is cleared too, so a frame cut by reset
         // leaves no stale bits that could leak into a later word.
         state   <= S_IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         par_err <= 1'b0;
         DOUT    <= '0;
         VALID   <= 1'b0;
         PERR    <= 1'b0;
         FERR    <= 1'b0;
         OVERRUN <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout; the default pulse
         // clears below are overridden by later assignments in this block.
         FERR    <= 1'b0;
         OVERRUN <= 1'b0;

         // Handshake frees the buffer; a frame completing on this same edge
         // overrides this with VALID <= 1 in the STOP branch.
         if (VALID && READY) begin
            VALID <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               if (SI) begin
                  state   <= S_DATA;
                  bit_cnt <= '0;
               end
            end

            S_DATA: begin
               // LSB arrives first, so shifting right leaves it in bit 0.
               shreg <= {SI, shreg[BITS-1:1]};
               if (bit_cnt == LAST_BIT) begin
                  state <= S_PARITY;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end

            S_PARITY: begin
               par_err <= SI ^ (^shreg);
               state   <= S_STOP;
            end

            S_STOP: begin
               if (SI) begin
                  // Bad stop bit: drop the frame. This bit is not a start.
                  FERR <= 1'b1;
               end else if (!VALID || READY) begin
                  DOUT  <= shreg;
                  PERR  <= par_err;
                  VALID <= 1'b1;
               end else begin
                  OVERRUN <= 1'b1;
               end
               state <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_deserializer
//
// Directed frames are driven on SI/READY. A frame-level model collects the
// bits of each frame in a queue and, once the whole frame is in, decides what
// the buffer must show. A compare process checks the DUT against the model on
// every falling edge; directed literal checks pin both the DUT and the model.
// -----------------------------------------------------------------------------
module tb_serial_frame_deserializer;

   localparam int B = 4;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         SI = 1'b0;
   logic         READY = 1'b0;
   logic [B-1:0] DOUT;
   logic         VALID;
   logic         PERR;
   logic         FERR;
   logic         OVERRUN;

   int tests = 0;
   int fails = 0;
   bit check_en = 1'b0;

   serial_frame_deserializer #(.BITS(B)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .SI     (SI),
      .READY  (READY),
      .DOUT   (DOUT),
      .VALID  (VALID),
      .PERR   (PERR),
      .FERR   (FERR),
      .OVERRUN(OVERRUN)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level reference model ----------------
   bit         in_frame;
   bit         frm[$];
   logic [B-1:0] m_dout = '0;
   bit         m_valid = 0, m_perr = 0, m_ferr = 0, m_ovr = 0;

   always @(posedge CLK or negedge RST) begin
      bit           was_valid;
      logic [B-1:0] d;
      if (!RST) begin
         in_frame = 0;
         frm.delete();
         m_dout = '0; m_valid = 0; m_perr = 0; m_ferr = 0; m_ovr = 0;
      end else begin
         was_valid = m_valid;
         m_ferr = 0;
         m_ovr  = 0;
         if (m_valid && READY) m_valid = 0;
         if (in_frame) begin
            frm.push_back(SI);
            if (frm.size() == B + 3) begin
               d = '0;
               for (int i = 0; i < B; i++) d[i] = frm[1 + i];
               if (frm[B + 2]) m_ferr = 1;
               else if (!was_valid || READY) begin
                  m_dout  = d;
                  m_perr  = ((^d) != frm[B + 1]);
                  m_valid = 1;
               end else m_ovr = 1;
               in_frame = 0;
            end
         end else if (SI) begin
            in_frame = 1;
            frm.delete();
            frm.push_back(1'b1);
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge CLK) begin
      if (check_en) begin
         check("cyc_valid", VALID, m_valid);
         check("cyc_ferr", FERR, m_ferr);
         check("cyc_overrun", OVERRUN, m_ovr);
         check("cyc_dout", DOUT, m_dout);
         if (m_valid) check("cyc_perr", PERR, m_perr);
         check("cyc_ferr_ovr_excl", FERR & OVERRUN, 0);
      end
   end

   // ---------------- stimulus helpers ----------------
   // Called at a falling edge; drives inputs, then waits for the next
   // falling edge so the outputs of the intervening rising edge are visible.
   task automatic step(input logic si, input logic rdy);
      SI    = si;
      READY = rdy;
      @(negedge CLK);
   endtask

   task automatic send(input logic [B-1:0] d, input logic par, input logic stp,
                       input logic rdy, input logic rdy_stop);
      step(1'b1, rdy);
      for (int i = 0; i < B; i++) step(d[i], rdy);
      step(par, rdy);
      step(stp, rdy_stop);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #2 RST = 1'b0;
      @(negedge CLK);
      check_en = 1'b1;
      step(0, 0);
      check("reset_valid", VALID, 0);
      check("reset_dout", DOUT, 0);
      check("reset_ferr_ovr", {FERR, OVERRUN, PERR}, 0);
      RST = 1'b1;
      step(0, 0);
      step(0, 0);

      // Good frame 4'hB, parity 1.
      step(1, 0);
      for (int i = 0; i < B; i++) step(i != 2, 0);
      step(1, 0);
      check("t1_not_valid_before_stop", VALID, 0);
      step(0, 0);
      check("t1_valid", VALID, 1);
      check("t1_dout", DOUT, 4'hB);
      check("t1_perr", PERR, 0);
      check("model_t1_dout", m_dout, 4'hB);
      step(0, 0);
      check("t1_hold", {VALID, DOUT}, {1'b1, 4'hB});
      step(0, 1);
      check("t1_consumed", VALID, 0);
      check("t1_dout_kept", DOUT, 4'hB);

      // Parity error still delivered.
      send(4'hB, 0, 0, 0, 0);
      check("t2_valid", VALID, 1);
      check("t2_dout", DOUT, 4'hB);
      check("t2_perr", PERR, 1);
      check("model_t2_perr", m_perr, 1);
      step(0, 1);

      // Framing error, then idle line produces nothing.
      send(4'hB, 1, 1, 0, 0);
      check("t3_ferr", FERR, 1);
      check("t3_valid", VALID, 0);
      check("model_t3_ferr", m_ferr, 1);
      step(0, 0);
      check("t3_ferr_pulse", FERR, 0);
      for (int i = 0; i < 10; i++) step(0, 0);
      check("t3_idle_no_frame", VALID, 0);

      // Overrun with READY low throughout.
      send(4'hB, 1, 0, 0, 0);
      send(4'h5, 0, 0, 0, 0);
      check("t4_overrun", OVERRUN, 1);
      check("t4_dout", DOUT, 4'hB);
      check("t4_valid", VALID, 1);
      check("model_t4_ovr", m_ovr, 1);
      step(0, 0);
      check("t4_overrun_pulse", OVERRUN, 0);
      step(0, 1);

      // Consume on the same edge as the second frame completes.
      send(4'hB, 1, 0, 0, 0);
      send(4'h5, 0, 0, 0, 1);
      check("t4b_no_overrun", OVERRUN, 0);
      check("t4b_dout", DOUT, 4'h5);
      check("t4b_valid", VALID, 1);
      step(0, 1);

      // Back-to-back frames, READY held high.
      send(4'hF, 0, 0, 1, 1);
      check("t5_first_dout", DOUT, 4'hF);
      check("t5_first_valid", VALID, 1);
      send(4'h0, 0, 0, 1, 1);
      check("t5_second_dout", DOUT, 4'h0);
      check("t5_second_valid", VALID, 1);
      step(0, 1);
      check("t5_drained", VALID, 0);

      // Reset mid-frame after two data bits of a frame.
      step(1, 0);
      step(1, 0);
      step(1, 0);
      RST = 1'b0;
      step(0, 0);
      check("t6_reset_outs", {DOUT, VALID, PERR, FERR, OVERRUN}, 0);
      step(0, 0);
      check("t6_reset_outs2", {DOUT, VALID, PERR, FERR, OVERRUN}, 0);
      RST = 1'b1;
      step(0, 0);
      check("t6_after_release", VALID, 0);
      send(4'h3, 0, 0, 0, 0);
      check("t6_dout", DOUT, 4'h3);
      check("t6_valid", VALID, 1);
      check("t6_perr", PERR, 0);
      step(0, 1);
      for (int i = 0; i < 4; i++) step(0, 0);
      check("t6_single_delivery", VALID, 0);

      check_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
